// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, entry-FSM encoding and limits shared by digit_entry and operands
package calc_pkg;

  localparam logic [7:0] KEY_0     = 8'h30;
  localparam logic [7:0] KEY_9     = 8'h39;
  localparam logic [7:0] KEY_ADD   = 8'h2B;
  localparam logic [7:0] KEY_SUB   = 8'h2D;
  localparam logic [7:0] KEY_MUL   = 8'h2A;
  localparam logic [7:0] KEY_DIV   = 8'h2F;
  localparam logic [7:0] KEY_ENTER = 8'h0D;
  localparam logic [7:0] KEY_BKSP  = 8'h08;
  localparam logic [7:0] KEY_ESC   = 8'h1B;

  localparam int MAX_DIGITS = 3;

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_ENTRY  = 2'd1;
  localparam logic [1:0] ST_FULL   = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  // digits output is count + 1, so "no digits" reads as 1
  localparam logic [2:0] DIGITS_NONE = 3'd1;

  function automatic logic is_operator(input logic [7:0] code);
    return (code == KEY_ADD) || (code == KEY_SUB) ||
           (code == KEY_MUL) || (code == KEY_DIV);
  endfunction

endpackage

// File: rtl/digit_entry_if.sv
// rtl/digit_entry_if.sv - keystroke input and operand-stage outputs of digit_entry
interface digit_entry_if;
  import calc_pkg::*;

  logic       key_valid;
  logic [7:0] key_code;
  logic [7:0] data;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [2:0] digits;
  logic       op;
  logic [7:0] opcode;
  logic       err;

  modport master (
    output key_valid, key_code,
    input  data, data1, data2, digits, op, opcode, err
  );

  modport slave (
    input  key_valid, key_code,
    output data, data1, data2, digits, op, opcode, err
  );

endinterface

// File: rtl/digit_entry_key_classify.sv
// rtl/digit_entry_key_classify.sv - combinational decode of an ASCII key code into key classes
module key_classify
  import calc_pkg::*;
(
  input  logic [7:0] key_code_i,
  output logic       is_digit_o,
  output logic       is_oper_o,
  output logic       is_enter_o,
  output logic       is_bksp_o,
  output logic       is_esc_o,
  output logic [3:0] digit_val_o
);

  logic [7:0] offset;

  assign offset      = key_code_i - KEY_0;
  assign digit_val_o = offset[3:0];
  assign is_digit_o  = (key_code_i >= KEY_0) && (key_code_i <= KEY_9);
  assign is_oper_o   = is_operator(key_code_i);
  assign is_enter_o  = (key_code_i == KEY_ENTER);
  assign is_bksp_o   = (key_code_i == KEY_BKSP);
  assign is_esc_o    = (key_code_i == KEY_ESC);

endmodule

// File: rtl/digit_entry.sv
// rtl/digit_entry.sv - assembles up to three decimal keystrokes and commits them with an op strobe
module digit_entry
  import calc_pkg::*;
(
  input  logic          FPGAClk,
  input  logic          rst_n,
  digit_entry_if.slave  bus
);

  logic       is_digit, is_oper, is_enter, is_bksp, is_esc;
  logic [3:0] digit_val;

  logic [1:0] state_q,  state_d;
  logic [7:0] data_q,   data_d;
  logic [7:0] data1_q,  data1_d;
  logic [7:0] data2_q,  data2_d;
  logic [2:0] digits_q, digits_d;
  logic [7:0] opcode_q, opcode_d;
  logic       op_q,     op_d;
  logic       err_q,    err_d;
  logic [1:0] eff_state;
  logic [7:0] digit_byte;

  key_classify u_classify (
    .key_code_i  (bus.key_code),
    .is_digit_o  (is_digit),
    .is_oper_o   (is_oper),
    .is_enter_o  (is_enter),
    .is_bksp_o   (is_bksp),
    .is_esc_o    (is_esc),
    .digit_val_o (digit_val)
  );

  // A key landing in COMMIT is handled as EMPTY so back-to-back keys are never dropped
  assign eff_state  = (state_q == ST_COMMIT) ? ST_EMPTY : state_q;
  assign digit_byte = {4'd0, digit_val};

  always_comb begin
    state_d  = (state_q == ST_COMMIT) ? ST_EMPTY : state_q;
    data_d   = data_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    digits_d = digits_q;
    opcode_d = opcode_q;
    op_d     = 1'b0;
    err_d    = 1'b0;

    if (bus.key_valid) begin
      if (is_esc) begin
        data_d   = 8'd0;
        data1_d  = 8'd0;
        data2_d  = 8'd0;
        digits_d = DIGITS_NONE;
        state_d  = ST_EMPTY;
      end else if (is_digit) begin
        case (eff_state)
          ST_EMPTY: begin
            // committed digits linger until here, so a new number clears every slot
            data_d   = digit_byte;
            data1_d  = 8'd0;
            data2_d  = 8'd0;
            digits_d = 3'd2;
            state_d  = ST_ENTRY;
          end
          ST_ENTRY: begin
            if (digits_q == 3'd2) begin
              data1_d  = digit_byte;
              digits_d = 3'd3;
            end else begin
              data2_d  = digit_byte;
              digits_d = 3'(MAX_DIGITS + 1);
              state_d  = ST_FULL;
            end
          end
          default: err_d = 1'b1;
        endcase
      end else if (is_bksp) begin
        if (eff_state == ST_EMPTY) begin
          err_d = 1'b1;
        end else begin
          digits_d = digits_q - 3'd1;
          state_d  = (digits_q == 3'd2) ? ST_EMPTY : ST_ENTRY;
          case (digits_q)
            3'd2:    data_d  = 8'd0;
            3'd3:    data1_d = 8'd0;
            default: data2_d = 8'd0;
          endcase
        end
      end else if (is_oper || is_enter) begin
        if (eff_state == ST_EMPTY) begin
          err_d = 1'b1;
        end else begin
          opcode_d = bus.key_code;
          op_d     = 1'b1;
          state_d  = ST_COMMIT;
        end
      end
    end
  end

  always_ff @(posedge FPGAClk) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      data_q   <= 8'd0;
      data1_q  <= 8'd0;
      data2_q  <= 8'd0;
      digits_q <= DIGITS_NONE;
      opcode_q <= 8'd0;
      op_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      digits_q <= digits_d;
      opcode_q <= opcode_d;
      op_q     <= op_d;
      err_q    <= err_d;
    end
  end

  assign bus.data   = data_q;
  assign bus.data1  = data1_q;
  assign bus.data2  = data2_q;
  assign bus.digits = digits_q;
  assign bus.opcode = opcode_q;
  assign bus.op     = op_q;
  assign bus.err    = err_q;

endmodule

// File: doc/digit_entry.md
# digit_entry

Captures decimal keystrokes from the keyboard decoder and assembles up to three digits for the `operands` stage. It holds the digits most-significant first, together with a digit count in the encoding `operands` expects. When an operator or Enter key terminates the number, it raises a one-cycle `op` strobe. It sits directly upstream of `operands`, and its outputs connect port-for-port to that block.

## Interface
- No parameters. Maximum entry length is fixed at 3 digits, matching `operands`.
- `FPGAClk  in  1`: system clock. All logic is on the rising edge.
- `rst_n  in  1`: synchronous, active-low reset.
- `key_valid  in  1`: one-cycle strobe from the keyboard decoder, qualifying `key_code`.
- `key_code  in  8`: ASCII key code. `0x30`–`0x39` are digits, `0x2B/0x2D/0x2A/0x2F` are operators, `0x0D` is Enter, `0x08` is Backspace, `0x1B` is Escape.
- `data  out  8`: first (most significant) digit, binary 0–9.
- `data1  out  8`: second digit, binary 0–9.
- `data2  out  8`: third digit, binary 0–9.
- `digits  out  3`: entered digit count + 1 (1 = none, 2/3/4 = one/two/three digits).
- `op  out  1`: one-cycle commit strobe to `operands`.
- `opcode  out  8`: ASCII of the terminating key (operator or `0x0D`), valid from the `op` cycle onward.
- `err  out  1`: one-cycle strobe for a rejected key.

## Operation
- State machine states: `EMPTY`, `ENTRY` (1–2 digits), `FULL` (3 digits), `COMMIT`. Only keys with `key_valid`=1 are acted on.
- Digit key:
  - In `EMPTY`: write the value (`key_code`−`0x30`) into `data` and set `digits`=2.
  - In `ENTRY`: write into the next free slot (`data1`, then `data2`) and increment `digits`.
  - Reaching 3 digits moves the state to `FULL`.
  - In `FULL`: the key is ignored and `err` pulses. All registers hold.
- Backspace:
  - In `ENTRY`/`FULL`: zero the last-filled slot and decrement `digits`. The state becomes `EMPTY` if the count reaches 0, otherwise `ENTRY`.
  - In `EMPTY`: pulse `err`.
- Operator or Enter:
  - In `ENTRY`/`FULL`: load `opcode`, go to `COMMIT`, and assert `op` for exactly one cycle.
  - In `EMPTY`: pulse `err` with no `op`.
- `COMMIT` always returns to `EMPTY` on the next cycle. `data*`, `digits` and `opcode` hold their committed values until the next digit key. That key zeroes all three digit registers, writes the new digit into `data`, and sets `digits`=2.
- Escape in any state: clear `data*` to 0, set `digits`=1, and go to `EMPTY`. No `err` is raised.
- Unused slots always read 0, so `operands` sees `data2`=0 in the 2-digit case.
- Any other `key_code`: ignored, no `err`.

## Timing
- Reset values: `data`/`data1`/`data2`=0, `digits`=1, `op`=0, `opcode`=0, `err`=0, state `EMPTY`.
- Reset takes priority over `key_valid` in the same cycle.
- Reset asserted during `COMMIT`: `op` is deasserted on the next edge.
- Latency: a key accepted at edge N updates the registers at edge N. `op`/`err` are high during cycle N→N+1 only.
- `data*` and `digits` are stable throughout the `op` cycle and remain stable after it, so `operands` latches them at edge N+1.
- `key_valid` arriving in `COMMIT` is processed as if the state were `EMPTY`. A digit starts a new number, and the `COMMIT`→`EMPTY` transition happens in the same edge. No key is dropped.
- Consecutive `key_valid` cycles are legal. Each one is processed.

## Structure
- Shared package `calc_pkg`:
  - key-code constants: `KEY_0`, `KEY_9`, `KEY_ADD`, `KEY_SUB`, `KEY_MUL`, `KEY_DIV`, `KEY_ENTER`, `KEY_BKSP`, `KEY_ESC`
  - the state encoding
  - `MAX_DIGITS`=3
- One sub-module, `key_classify`: combinational decode of `key_code` into `is_digit`, `is_oper`, `is_enter`, `is_bksp`, `is_esc`, plus a 4-bit digit value. `operands` reuses the same package constants.

## Test plan
- Reset, then keys `'1'`,`'2'`,`'3'`,`'+'` → `data`=1, `data1`=2, `data2`=3, `digits`=4, `op` high for 1 cycle, `opcode`=`0x2B`. The downstream `operands` yields `a`=123.
- Keys `'7'`, Enter → `data`=7, `data1`=0, `data2`=0, `digits`=2, `op` pulse. Then `'4'`,`'2'`,`'*'` → `data`=4, `data1`=2, `data2`=0, `digits`=3, and `operands` yields 42.
- `'9'`,`'9'`,`'9'`,`'5'` → fourth key raises `err`, `data2` stays 9, `digits`=4, no `op`.
- `'5'`,`'6'`, Backspace, `'8'`, `'-'` → `data`=5, `data1`=8, `digits`=3. `'+'` with no digits entered → `err` pulse, no `op`.
- `'3'`,`'4'`, Escape → all `data*`=0, `digits`=1. Then assert `rst_n`=0 in the same cycle as a `key_valid` for `'6'` → all outputs at reset values.
- Back-to-back `key_valid` for `'8'`, `'/'`, `'2'` → `op` pulses on the second key's cycle. On the third key, `data`=2, `data1`=0, `data2`=0, `digits`=2 with no gap cycle.
